// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into the instruction memory write port,
// holding the processor in reset until a complete image has been written.
module imem_loader #(
   parameter int DEPTH   = 256,
   parameter int AW      = 8,
   parameter int TIMEOUT = 1000000
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          cpu_reset,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW:0]   word_count
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [31:0]   word_q, word_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   word_count_q, word_count_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          rx_ready_q, mem_we_q, cpu_reset_q, busy_q, done_q, error_q;
   logic [31:0]   mem_addr_q, mem_wdata_q;

   logic          accept;
   logic          tmo_hit;
   logic [15:0]   len_full;

   assign accept   = rx_valid && rx_ready_q;
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
   assign len_full = {rx_data, len_q[7:0]};

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_d       = word_q;
      byte_idx_d   = byte_idx_q;
      ptr_d        = ptr_q;
      word_count_d = word_count_q;
      tmo_d        = tmo_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d      = S_LEN_LO;
               len_d        = '0;
               byte_idx_d   = '0;
               ptr_d        = '0;
               word_count_d = '0;
               tmo_d        = '0;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = rx_data;
               tmo_d      = '0;
               state_d    = S_LEN_HI;
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d = len_full;
               tmo_d = '0;
               if (len_full == 16'd0) begin
                  state_d = S_DONE;
               end else if (32'(len_full) > 32'(DEPTH)) begin
                  state_d = S_ERR;
               end else begin
                  state_d    = S_DATA;
                  byte_idx_d = '0;
               end
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               tmo_d = '0;
               if (byte_idx_q == 2'd3) begin
                  state_d = S_WRITE;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WRITE: begin
            word_count_d = word_count_q + (AW+1)'(1);
            byte_idx_d   = '0;
            // ptr stays on the last word when the image ends so it never passes DEPTH-1
            if (16'(ptr_q) + 16'd1 == len_q) begin
               state_d = S_DONE;
            end else begin
               ptr_d   = ptr_q + AW'(1);
               state_d = S_DATA;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         word_q       <= '0;
         byte_idx_q   <= '0;
         ptr_q        <= '0;
         word_count_q <= '0;
         tmo_q        <= '0;
         rx_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_reset_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_q       <= word_d;
         byte_idx_q   <= byte_idx_d;
         ptr_q        <= ptr_d;
         word_count_q <= word_count_d;
         tmo_q        <= tmo_d;
         // Outputs are decoded from the next state so they line up with state_q
         rx_ready_q   <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
         mem_we_q     <= (state_d == S_WRITE);
         mem_addr_q   <= {{(30-AW){1'b0}}, ptr_d, 2'b00};
         if (state_d == S_WRITE) begin
            mem_wdata_q <= word_d;
         end
         cpu_reset_q  <= (state_d != S_DONE);
         busy_q       <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                         (state_d == S_DATA) || (state_d == S_WRITE);
         done_q       <= (state_d == S_DONE);
         error_q      <= (state_d == S_ERR);
      end
   end

   assign rx_ready   = rx_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue,
// a monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;

   localparam int DEPTH   = 256;
   localparam int AW      = 8;
   localparam int TIMEOUT = 40;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   word_count;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [63:0]   exp_q[$];

   imem_loader #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back({addr, data});
   endtask

   // Monitor: every write pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (reset_n === 1'b1 && mem_we === 1'b1) begin
         $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(mem_we), 32'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("write_addr", mem_addr, e[63:32]);
            check("write_data", mem_wdata, e[31:0]);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_accept_timeout: byte 0x%02h never accepted, rx_ready=%b", b, rx_ready);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      $display("byte 0x%02h sent", b);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_end_timeout: done=%b error=%b", done, error);
      end
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int c);
      for (int i = 0; i < c; i++) @(negedge clk);
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;

      // 1: reset state
      idle_cycles(3);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      $display("reset checked");
      reset_n = 1'b1;
      idle_cycles(2);

      // 2: two-word image
      pulse_start();
      check("t2_busy", 32'(busy), 32'd1);
      check("t2_cpu_reset_loading", 32'(cpu_reset), 32'd1);
      expect_write(32'h0, 32'h12345678);
      expect_write(32'h4, 32'hDEADBEEF);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      wait_end();
      check("t2_done", 32'(done), 32'd1);
      check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
      check("t2_word_count", 32'(word_count), 32'd2);
      check("t2_busy_end", 32'(busy), 32'd0);
      check("t2_pending", 32'(exp_q.size()), 32'd0);
      // Bytes after the image are not consumed
      rx_data  = 8'h99;
      rx_valid = 1'b1;
      idle_cycles(3);
      check("t2_extra_rx_ready", 32'(rx_ready), 32'd0);
      check("t2_extra_done", 32'(done), 32'd1);
      rx_valid = 1'b0;

      // 3: N = 257 exceeds DEPTH
      pulse_start();
      check("t3_cpu_reset_restart", 32'(cpu_reset), 32'd1);
      send_byte(8'h01); send_byte(8'h01);
      wait_end();
      check("t3_error", 32'(error), 32'd1);
      check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t3_done", 32'(done), 32'd0);
      check("t3_rx_ready", 32'(rx_ready), 32'd0);

      // 4: N = 0 goes straight to DONE
      pulse_start();
      check("t4_error_cleared", 32'(error), 32'd0);
      send_byte(8'h00); send_byte(8'h00);
      wait_end();
      check("t4_done", 32'(done), 32'd1);
      check("t4_word_count", 32'(word_count), 32'd0);

      // 5: stall mid-word aborts, then a new image recovers
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      idle_cycles(TIMEOUT + 5);
      check("t5_error", 32'(error), 32'd1);
      check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t5_word_count", 32'(word_count), 32'd0);
      pulse_start();
      expect_write(32'h0, 32'hDDCCBBAA);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      idle_cycles(TIMEOUT - 8);
      check("t5_near_timeout_busy", 32'(busy), 32'd1);
      send_byte(8'hCC); send_byte(8'hDD);
      wait_end();
      check("t5_done", 32'(done), 32'd1);
      check("t5_word_count", 32'(word_count), 32'd1);

      // 6a: async reset between bytes 2 and 3 of word 5
      pulse_start();
      send_byte(8'h06); send_byte(8'h00);
      for (int k = 0; k < 5; k++) begin
         expect_write(32'(k * 4), 32'hA0221100 + 32'(k));
         send_byte(8'(k)); send_byte(8'h11); send_byte(8'h22); send_byte(8'hA0);
      end
      send_byte(8'h05); send_byte(8'h11);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_reset_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t6_reset_mem_we", 32'(mem_we), 32'd0);
      check("t6_reset_rx_ready", 32'(rx_ready), 32'd0);
      check("t6_reset_busy", 32'(busy), 32'd0);
      check("t6_reset_word_count", 32'(word_count), 32'd0);
      idle_cycles(2);
      reset_n = 1'b1;
      idle_cycles(2);

      // 6b: start during DATA ignored; rx_valid held across WRITE not consumed
      pulse_start();
      expect_write(32'h0, 32'h04030201);
      expect_write(32'h4, 32'h08070605);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      pulse_start();
      check("t6_start_ignored_busy", 32'(busy), 32'd1);
      check("t6_start_ignored_count", 32'(word_count), 32'd1);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      wait_end();
      check("t6_done", 32'(done), 32'd1);
      check("t6_word_count", 32'(word_count), 32'd2);

      idle_cycles(3);
      check("final_pending", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "global timeout");
   end

endmodule
